// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer; FETCH_MISALIGN_CHK_EN enables misaligned-redirect fault
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FLUSH,
        S_FAULT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] redirect_pc_aligned;
    logic        misaligned;
    logic        redirect_take;

    assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;
    assign redirect_take       = redirect_valid && (state != S_FAULT);

`ifdef FETCH_MISALIGN_CHK_EN
    assign misaligned = |redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_fault <= 1'b0;
        end else if (redirect_take && misaligned) begin
            fetch_fault <= 1'b1;
        end
    end
`else
    assign misaligned  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect_take) begin
            state_nxt = misaligned ? S_FAULT : S_FLUSH;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_REQ;
                S_FLUSH: state_nxt = S_REQ;
                default: state_nxt = state;
            endcase
        end
    end

    // Hold off new requests while the decoder is refusing the word we already have.
    always_comb begin
        imem_req = (state == S_REQ) && !(instr_valid && stall);
    end

    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
        end else if (redirect_take) begin
            // A same-cycle ack belongs to the abandoned path and is dropped.
            if (!misaligned) begin
                pc <= redirect_pc_aligned;
            end
            instr_valid <= 1'b0;
        end else if (state == S_REQ) begin
            if (imem_req && imem_ack) begin
                instr       <= imem_rdata;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + 32'd4;
            end else if (!stall) begin
                instr_valid <= 1'b0;
            end
        end else begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with memory model and scoreboard
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        fetch_fault;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_lo;
    logic [31:0] w_rpc;
    logic [31:0] w_instr;
    logic [31:0] w_ipc;
    logic        w_valid;
    logic        w_fault;

    assign w_lo    = 1'b0;
    assign w_rpc   = 32'h0;
    assign w_ack   = w_req;
    assign w_rdata = ~w_addr;

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .stall(stall), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .fetch_fault(fetch_fault)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .redirect_valid(w_lo),
        .redirect_pc(w_rpc), .stall(w_lo), .instr(w_instr), .instr_pc(w_ipc),
        .instr_valid(w_valid), .fetch_fault(w_fault)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          lat = 0;
    int          wait_cnt = 0;
    bit          stray_ack = 1'b0;
    logic [31:0] model_pc = 32'h0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ipc;
        logic        wchk;
        logic [31:0] wpc;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: memory model answers, decoder consumes, reference pc advances.
    task automatic cycle();
        bit          acked;
        bit          req_s;
        logic [31:0] e;
        acked = 1'b0;
        #1;
        imem_ack = 1'b0;
        if (imem_req && wait_cnt == lat) begin
            acked      = 1'b1;
            imem_ack   = 1'b1;
            imem_rdata = ~model_pc;
            chk("imem_addr", imem_addr, model_pc);
            if (!redirect_valid) exp_q.push_back(model_pc);
        end else if (stray_ack && !imem_req) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end
        req_s = imem_req;
        if (instr_valid && !stall) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_spurious: got instr_pc %h expected no word", instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr_pc", instr_pc, e);
                chk("sb_instr", instr, ~e);
            end
        end
        @(posedge clk);
        if (redirect_valid) begin
            model_pc = redirect_pc & 32'hFFFF_FFFC;
            wait_cnt = 0;
        end else if (acked) begin
            model_pc = model_pc + 32'd4;
            wait_cnt = 0;
        end else if (req_s) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    initial begin
        int vcnt;
        int dbl;
        int changes;
        bit prev_v;
        bit found;
        logic [31:0] prev_addr;

        tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   1'b1, 32'hFFFF_FFF8};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,   1'b1, 32'hFFFF_FFFC};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h8,   1'b1, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h8,   1'b1, 32'h4};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8,   1'b0, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC,   1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 32'h40,  1'b1, 32'h14,  1'b1, 32'h10,  1'b0, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h40,  1'b0, 32'h10,  1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h40,  1'b0, 32'h10,  1'b0, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h44,  1'b1, 32'h40,  1'b0, 32'h0};
        tbl[12] = '{1'b0, 1'b1, 32'h80,  1'b1, 32'h48,  1'b1, 32'h44,  1'b0, 32'h0};
        tbl[13] = '{1'b0, 1'b1, 32'h200, 1'b0, 32'h80,  1'b0, 32'h44,  1'b0, 32'h0};
        tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h200, 1'b0, 32'h44,  1'b0, 32'h0};
        tbl[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h44,  1'b0, 32'h0};
        tbl[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200, 1'b0, 32'h0};

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_fault", fetch_fault, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            stall = tbl[i].stall;
            redirect_valid = tbl[i].rv;
            redirect_pc = tbl[i].rpc;
            #1;
            chk($sformatf("t%0d_req", i), imem_req, tbl[i].req);
            chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("t%0d_valid", i), instr_valid, tbl[i].valid);
            chk($sformatf("t%0d_instr_pc", i), instr_pc, tbl[i].ipc);
            if (tbl[i].wchk) begin
                chk($sformatf("t%0d_wrap_valid", i), w_valid, 1'b1);
                chk($sformatf("t%0d_wrap_pc", i), w_ipc, tbl[i].wpc);
                chk($sformatf("t%0d_wrap_instr", i), w_instr, ~tbl[i].wpc);
            end
            cycle();
        end
        stall = 1'b0; redirect_valid = 1'b0;

        lat = 3; vcnt = 0; dbl = 0; changes = 0; prev_v = 1'b0; prev_addr = imem_addr;
        for (int i = 0; i < 16; i++) begin
            if (instr_valid) vcnt++;
            if (instr_valid && prev_v) dbl++;
            if (imem_addr != prev_addr) changes++;
            prev_v = instr_valid;
            prev_addr = imem_addr;
            cycle();
        end
        chk("slow_valid_count", vcnt, 4);
        chk("slow_valid_pulse", dbl, 0);
        chk("slow_addr_changes", changes, 3);

        lat = 0; redirect_valid = 1'b1; redirect_pc = 32'h10;
        cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (instr_valid) break;
            cycle();
        end
        chk("stall_wait_valid", instr_valid, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_req", imem_req, 1'b0);
            chk("stall_valid", instr_valid, 1'b1);
            chk("stall_instr_pc", instr_pc, 32'h10);
            chk("stall_instr", instr, ~32'h10);
            cycle();
        end
        stall = 1'b0;
        cycle();
        chk("stall_next_valid", instr_valid, 1'b1);
        chk("stall_next_pc", instr_pc, 32'h14);

        lat = 2; found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req && wait_cnt == lat && !instr_valid) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        chk("redir_setup", found, 1'b1);
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        cycle();
        stall = 1'b0; redirect_valid = 1'b0; lat = 0;
        #1;
        chk("redir_bubble_req", imem_req, 1'b0);
        chk("redir_bubble_valid", instr_valid, 1'b0);
        cycle();
        chk("redir_req", imem_req, 1'b1);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_req_valid", instr_valid, 1'b0);
        cycle();
        chk("redir_first_valid", instr_valid, 1'b1);
        chk("redir_first_pc", instr_pc, 32'h100);

        redirect_valid = 1'b1; redirect_pc = 32'h102;
        cycle();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mis_fault", fetch_fault, 1'b1);
            chk("mis_req", imem_req, 1'b0);
            chk("mis_valid", instr_valid, 1'b0);
            cycle();
        end
`else
        #1;
        chk("mis_fault", fetch_fault, 1'b0);
        chk("mis_flush_req", imem_req, 1'b0);
        cycle();
        cycle();
        chk("mis_valid", instr_valid, 1'b1);
        chk("mis_pc", instr_pc, 32'h100);
`endif

        lat = 3;
        cycle();
        cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", imem_req, 1'b0);
        chk("arst_valid", instr_valid, 1'b0);
        chk("arst_instr_pc", instr_pc, 32'h0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_fault", fetch_fault, 1'b0);
        chk("arst_addr", imem_addr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0;
        exp_q.delete();
        model_pc = 32'h0; wait_cnt = 0; lat = 0;
        stray_ack = 1'b1;
        cycle();
        stray_ack = 1'b0;
        chk("stray_valid", instr_valid, 1'b0);
        chk("stray_req", imem_req, 1'b1);
        chk("stray_addr", imem_addr, 32'h0);
        cycle();
        chk("post_rst_valid", instr_valid, 1'b1);
        chk("post_rst_pc", instr_pc, 32'h0);
        cycle();
        cycle();
        chk("wrap_fault", w_fault, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
